// File: rtl/product_term_array_if.sv
// Configuration and evaluation bundle of the product-term array.
// The master side loads the bitstream and drives the array inputs; the slave side is the array.
interface product_term_array_if #(
  parameter int N_IN = 3,
  parameter int N_PT = 2
);
  logic            cfg_start;
  logic            cfg_valid;
  logic            cfg_bit;
  logic            cfg_ready;
  logic            cfg_out;
  logic            cfg_done;
  logic [N_IN-1:0] in;
  logic [N_PT-1:0] pt_out;
  logic            pt_valid;

  modport master (
    output cfg_start, cfg_valid, cfg_bit, in,
    input  cfg_ready, cfg_out, cfg_done, pt_out, pt_valid
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_bit, in,
    output cfg_ready, cfg_out, cfg_done, pt_out, pt_valid
  );
endinterface

// File: rtl/product_term_array.sv
// Serially configured AND-array for the macrocell model: a shift chain holds true/complement
// literal connections per term, and all terms are evaluated and registered every cycle once loaded.
module product_term_array #(
  parameter int N_IN         = 3,
  parameter int N_PT         = 2,
  parameter bit EMPTY_PT_VAL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  product_term_array_if.slave  bus
);

  localparam int CFG_BITS = N_PT * 2 * N_IN;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  state_e              state_q;
  logic [CFG_BITS-1:0] cfg_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                cfg_ready_q;
  logic                cfg_done_q;
  logic                cfg_out_q;
  logic [N_PT-1:0]     pt_out_q;
  logic                pt_valid_q;
  logic [N_PT-1:0]     pt_eval_d;
  logic                term_acc;
  logic                term_hit;

  // A term with no connected literal falls back to EMPTY_PT_VAL instead of a vacuous 1.
  always_comb begin
    // NOTE: every variable gets a default before the loops, so no path leaves a stale value (no latch).
    pt_eval_d = '0;
    term_acc  = 1'b1;
    term_hit  = 1'b0;
    for (int p = 0; p < N_PT; p++) begin
      // NOTE: blocking assignments here so the accumulator updates sequentially within the loop.
      term_acc = 1'b1;
      term_hit = 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        if (cfg_q[p*2*N_IN + 2*i]) begin
          term_acc = term_acc & bus.in[i];
          term_hit = 1'b1;
        end
        if (cfg_q[p*2*N_IN + 2*i + 1]) begin
          term_acc = term_acc & ~bus.in[i];
          term_hit = 1'b1;
        end
      end
      pt_eval_d[p] = term_hit ? term_acc : EMPTY_PT_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the config chain is a small flop register, so clearing it on reset is cheap and
      // guarantees a partial load leaves no residue in the readback stream.
      state_q     <= IDLE;
      cfg_q       <= '0;
      cnt_q       <= '0;
      cfg_ready_q <= 1'b0;
      cfg_done_q  <= 1'b0;
      cfg_out_q   <= 1'b0;
      pt_out_q    <= '0;
      pt_valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.cfg_start) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            cfg_ready_q <= 1'b1;
          end
        end
        LOAD: begin
          // A restart wins over a coincident bit, which is dropped.
          if (bus.cfg_start) begin
            cnt_q <= '0;
          end else if (bus.cfg_valid) begin
            cfg_q     <= {bus.cfg_bit, cfg_q[CFG_BITS-1:1]};
            cfg_out_q <= cfg_q[0];
            cnt_q     <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(CFG_BITS - 1)) begin
              state_q     <= ACTIVE;
              cfg_done_q  <= 1'b1;
              cfg_ready_q <= 1'b0;
            end
          end
        end
        ACTIVE: begin
          if (bus.cfg_start) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            cfg_ready_q <= 1'b1;
            cfg_done_q  <= 1'b0;
            pt_valid_q  <= 1'b0;
            pt_out_q    <= '0;
          end else begin
            pt_out_q   <= pt_eval_d;
            pt_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          cfg_ready_q <= 1'b0;
          cfg_done_q  <= 1'b0;
          pt_out_q    <= '0;
          pt_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.cfg_done  = cfg_done_q;
  assign bus.cfg_out   = cfg_out_q;
  assign bus.pt_out    = pt_out_q;
  assign bus.pt_valid  = pt_valid_q;

endmodule

// File: tb/tb_product_term_array.sv
// Directed bench for product_term_array: 3x2 arrays built with both empty-term values share stimulus,
// and a 6x4 array is checked against a reference model with random configurations.
module tb_product_term_array;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  product_term_array_if #(.N_IN(3), .N_PT(2)) s_if ();
  product_term_array_if #(.N_IN(3), .N_PT(2)) e_if ();
  product_term_array_if #(.N_IN(6), .N_PT(4)) b_if ();

  assign e_if.cfg_start = s_if.cfg_start;
  assign e_if.cfg_valid = s_if.cfg_valid;
  assign e_if.cfg_bit   = s_if.cfg_bit;
  assign e_if.in        = s_if.in;

  product_term_array #(.N_IN(3), .N_PT(2), .EMPTY_PT_VAL(1'b0)) u_dut_e0 (.clk(clk), .rst(rst), .bus(s_if.slave));
  product_term_array #(.N_IN(3), .N_PT(2), .EMPTY_PT_VAL(1'b1)) u_dut_e1 (.clk(clk), .rst(rst), .bus(e_if.slave));
  product_term_array #(.N_IN(6), .N_PT(4), .EMPTY_PT_VAL(1'b1)) u_dut_big (.clk(clk), .rst(rst), .bus(b_if.slave));

  localparam logic [11:0] PAT_T2 = 12'h601;  // pt0 = in0 ; pt1 = ~in1 & in2
  localparam logic [11:0] PAT_T3 = 12'h00C;  // pt0 = in1 & ~in1 ; pt1 empty

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] model(input logic [47:0] c, input logic [5:0] x,
                                       input int nin, input int npt, input logic empty_val);
    logic [3:0] r;
    logic       acc;
    logic       hit;
    r = '0;
    for (int p = 0; p < npt; p++) begin
      acc = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < nin; i++) begin
        if (c[p*2*nin + 2*i])     begin acc = acc & x[i];  hit = 1'b1; end
        if (c[p*2*nin + 2*i + 1]) begin acc = acc & ~x[i]; hit = 1'b1; end
      end
      r[p] = hit ? acc : empty_val;
    end
    return r;
  endfunction

  // Shifts 12 bits into the small arrays, optionally checking readback and ready across gaps.
  task automatic shift_s(input logic [11:0] pat, input logic [11:0] old, input bit chk,
                         input int gap_a, input int gap_b);
    for (int k = 0; k < 12; k++) begin
      s_if.cfg_valid = 1'b1;
      s_if.cfg_bit   = pat[k];
      if (chk) check("ready_load", s_if.cfg_ready, 1);
      tick();
      s_if.cfg_valid = 1'b0;
      if (chk) check("readback", s_if.cfg_out, old[k]);
      if (k == gap_a || k == gap_b) begin
        repeat (3) begin
          tick();
          if (chk) check("ready_gap", s_if.cfg_ready, 1);
        end
      end
    end
    check("done_after_load", s_if.cfg_done, 1);
    check("ready_after_load", s_if.cfg_ready, 0);
    check("valid_e0", s_if.pt_valid, 0);
  endtask

  task automatic load_s(input logic [11:0] pat, input logic [11:0] old, input bit chk,
                        input int gap_a, input int gap_b);
    s_if.cfg_start = 1'b1;
    tick();
    s_if.cfg_start = 1'b0;
    check("start_clears_valid", s_if.pt_valid, 0);
    check("start_clears_pt", s_if.pt_out, 0);
    check("start_clears_done", s_if.cfg_done, 0);
    shift_s(pat, old, chk, gap_a, gap_b);
  endtask

  task automatic sweep_s(input logic [11:0] pat);
    for (int x = 0; x < 8; x++) begin
      s_if.in = 3'(x);
      tick();
      check("sweep_valid", s_if.pt_valid, 1);
      check("sweep_e0", s_if.pt_out, model({36'b0, pat}, 6'(x), 3, 2, 1'b0));
      check("sweep_e1", e_if.pt_out, model({36'b0, pat}, 6'(x), 3, 2, 1'b1));
    end
  endtask

  task automatic big_run(input int n_pat, input int n_vec);
    logic [47:0] pat;
    logic [5:0]  x;
    for (int j = 0; j < n_pat; j++) begin
      for (int k = 0; k < 48; k++) pat[k] = ($urandom_range(0, 3) == 0);
      if (j % 2 == 0) pat[47:36] = '0;
      b_if.cfg_start = 1'b1;
      tick();
      b_if.cfg_start = 1'b0;
      for (int k = 0; k < 48; k++) begin
        b_if.cfg_valid = 1'b1;
        b_if.cfg_bit   = pat[k];
        tick();
      end
      b_if.cfg_valid = 1'b0;
      check("big_done", b_if.cfg_done, 1);
      for (int v = 0; v < n_vec; v++) begin
        x = 6'($urandom_range(0, 63));
        b_if.in = x;
        tick();
        check("big_pt", b_if.pt_out, model(pat, x, 6, 4, 1'b1));
      end
      check("big_valid", b_if.pt_valid, 1);
    end
  endtask

  initial begin
    s_if.cfg_start = 1'b0; s_if.cfg_valid = 1'b0; s_if.cfg_bit = 1'b0; s_if.in = '0;
    b_if.cfg_start = 1'b0; b_if.cfg_valid = 1'b0; b_if.cfg_bit = 1'b0; b_if.in = '0;

    // Reset state, then bit pulses in IDLE must be ignored.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_pt_out", s_if.pt_out, 0);
    check("rst_pt_valid", s_if.pt_valid, 0);
    check("rst_ready", s_if.cfg_ready, 0);
    check("rst_done", s_if.cfg_done, 0);
    check("rst_cfg_out", s_if.cfg_out, 0);
    s_if.cfg_bit = 1'b1;
    repeat (3) begin
      s_if.cfg_valid = 1'b1;
      tick();
      s_if.cfg_valid = 1'b0;
      tick();
    end
    check("idle_cfg_out", s_if.cfg_out, 0);
    check("idle_ready", s_if.cfg_ready, 0);
    check("idle_done", s_if.cfg_done, 0);

    // Basic load; readback of zeros proves the IDLE pulses did not shift.
    load_s(PAT_T2, 12'h000, 1'b1, -1, -1);
    s_if.in = 3'b101;
    tick();
    check("t2_first_valid", s_if.pt_valid, 1);
    check("t2_in101", s_if.pt_out, 2'b11);
    s_if.in = 3'b111;
    tick();
    check("t2_in111", s_if.pt_out, 2'b01);
    s_if.in = 3'b000;
    tick();
    check("t2_in000", s_if.pt_out, 2'b00);
    sweep_s(PAT_T2);

    // Contradictory term and empty term, for both empty-term values.
    load_s(PAT_T3, PAT_T2, 1'b1, -1, -1);
    s_if.in = 3'b010;
    tick();
    check("t3_e0", s_if.pt_out, 2'b00);
    check("t3_e1", e_if.pt_out, 2'b10);
    sweep_s(PAT_T3);

    // Same pattern with valid gaps after bits 4 and 9.
    load_s(PAT_T2, PAT_T3, 1'b1, 3, 8);
    sweep_s(PAT_T2);

    // Restart mid-load with a coincident bit, then readback of the completed load.
    s_if.cfg_start = 1'b1;
    tick();
    s_if.cfg_start = 1'b0;
    s_if.cfg_bit   = 1'b1;
    repeat (5) begin
      s_if.cfg_valid = 1'b1;
      tick();
    end
    s_if.cfg_start = 1'b1;
    s_if.cfg_valid = 1'b1;
    tick();
    s_if.cfg_start = 1'b0;
    s_if.cfg_valid = 1'b0;
    check("restart_ready", s_if.cfg_ready, 1);
    check("restart_done", s_if.cfg_done, 0);
    shift_s(PAT_T2, 12'h000, 1'b0, -1, -1);
    sweep_s(PAT_T2);
    s_if.in = 3'b101;
    tick();
    load_s(PAT_T3, PAT_T2, 1'b1, -1, -1);
    sweep_s(PAT_T3);

    // Reset in the middle of a load, then clean reload with no residue.
    s_if.cfg_start = 1'b1;
    tick();
    s_if.cfg_start = 1'b0;
    s_if.cfg_bit   = 1'b1;
    repeat (7) begin
      s_if.cfg_valid = 1'b1;
      tick();
    end
    s_if.cfg_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_done", s_if.cfg_done, 0);
    check("midrst_ready", s_if.cfg_ready, 0);
    check("midrst_cfg_out", s_if.cfg_out, 0);
    check("midrst_valid", s_if.pt_valid, 0);
    load_s(PAT_T3, 12'h000, 1'b1, -1, -1);
    sweep_s(PAT_T3);
    load_s(PAT_T2, PAT_T3, 1'b1, -1, -1);
    sweep_s(PAT_T2);

    // Larger array against the reference model.
    big_run(10, 100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
